// File: rtl/wb_write_arbiter.sv
`default_nettype none
//============================================================================
// Module   : wb_write_arbiter
// Brief    : Arbitrates ALU and load writebacks onto a single register-file
//            write port. Loads win by default; a waiting ALU is granted
//            once it has stalled for MAX_WAIT cycles.
// Revision : 1.0 - initial release
//============================================================================
module wb_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              rf_stall,
  output logic              RegW_EN_out,
  output logic [ADDR_W-1:0] addrD_out,
  output logic [DATA_W-1:0] WriteData
);

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] r_aluWait;
  logic       w_aluGrant;
  logic       w_memGrant;
  logic       w_aluStarved;

  assign w_aluStarved = (r_aluWait == C_MAX_WAIT);

  always_comb begin
    w_aluGrant = 1'b0;
    w_memGrant = 1'b0;
    if (!reset && !rf_stall) begin
      if (alu_valid && (!mem_valid || w_aluStarved)) begin
        w_aluGrant = 1'b1;
      end else if (mem_valid) begin
        w_memGrant = 1'b1;
      end
    end
  end

  assign alu_ready = w_aluGrant;
  assign mem_ready = w_memGrant;

  // Stall cycles (including rf_stall cycles) accumulate; any ALU transfer or idle ALU clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aluWait <= 4'd0;
    end else if (!alu_valid || w_aluGrant) begin
      r_aluWait <= 4'd0;
    end else if (!w_aluStarved) begin
      r_aluWait <= r_aluWait + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegW_EN_out <= 1'b0;
      addrD_out   <= '0;
      WriteData   <= '0;
    end else begin
      RegW_EN_out <= w_aluGrant | w_memGrant;
      if (w_aluGrant) begin
        addrD_out <= alu_addr;
        WriteData <= alu_data;
      end else if (w_memGrant) begin
        addrD_out <= mem_addr;
        WriteData <= mem_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_wb_write_arbiter
// Brief    : Self-checking bench for wb_write_arbiter with a write-queue
//            reference model, directed scenarios and a random stream.
// Revision : 1.0 - initial release
//============================================================================
module tb_wb_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 3;

  logic          clk;
  logic          reset;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          rf_stall;
  logic          RegW_EN_out;
  logic [AW-1:0] addrD_out;
  logic [DW-1:0] WriteData;

  wb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .rf_stall    (rf_stall),
    .RegW_EN_out (RegW_EN_out),
    .addrD_out   (addrD_out),
    .WriteData   (WriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  int            errors = 0;
  int            checks = 0;
  int            mWait = 0;
  int            xfers = 0;
  int            pulses = 0;
  logic [AW-1:0] lastAddr = '0;
  logic [DW-1:0] lastData = '0;
  bit            grantAlu = 1'b0;
  bit            grantMem = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks outputs for the current cycle, advances the model, then crosses one clock edge.
  task automatic tick();
    wr_t w;
    bit  expEn;
    bit  expAlu;
    bit  expMem;
    #1;
    expEn = 1'b0;
    if (q.size() > 0) begin
      w        = q.pop_front();
      expEn    = 1'b1;
      lastAddr = w.a;
      lastData = w.d;
    end
    chk("wen", {63'd0, RegW_EN_out}, {63'd0, expEn});
    chk("waddr", {59'd0, addrD_out}, {59'd0, lastAddr});
    chk("wdata", {32'd0, WriteData}, {32'd0, lastData});
    if (RegW_EN_out === 1'b1) pulses++;

    expAlu = 1'b0;
    expMem = 1'b0;
    if (!reset && !rf_stall) begin
      if (alu_valid && mem_valid) begin
        if (mWait == MW) expAlu = 1'b1;
        else expMem = 1'b1;
      end else begin
        expAlu = alu_valid;
        expMem = mem_valid;
      end
    end
    chk("alu_ready", {63'd0, alu_ready}, {63'd0, expAlu});
    chk("mem_ready", {63'd0, mem_ready}, {63'd0, expMem});

    if (reset) begin
      q.delete();
      mWait    = 0;
      lastAddr = '0;
      lastData = '0;
    end else begin
      if (expAlu) begin q.push_back('{a: alu_addr, d: alu_data}); xfers++; end
      if (expMem) begin q.push_back('{a: mem_addr, d: mem_data}); xfers++; end
      if (alu_valid && !expAlu) mWait = (mWait < MW) ? mWait + 1 : MW;
      else mWait = 0;
    end
    grantAlu = expAlu;
    grantMem = expMem;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    rf_stall  = 1'b0;
    @(negedge clk);
    tick();
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    reset     = 1'b0;
    tick();

    // Single ALU write
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    tick();
    tick();

    // Conflict: mem, mem, mem, then ALU
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h0000_3333;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h0000_7777;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (grantAlu) alu_valid = 1'b0;
      if (grantMem) mem_data = mem_data + 32'd1;
    end
    chk("conflict_4th_alu", {63'd0, grantAlu}, 64'd1);
    mem_valid = 1'b0;
    tick();
    tick();

    // Stall with a pending load
    mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'hCAFE_0012;
    rf_stall  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rf_stall = 1'b0;
    tick();
    mem_valid = 1'b0;
    tick();
    tick();

    // Stall with ALU waiting: ALU wins once the stall lifts
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1111_0001;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h2222_0002;
    rf_stall  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rf_stall = 1'b0;
    tick();
    chk("stall_alu_first", {63'd0, grantAlu}, 64'd1);
    alu_valid = 1'b0;
    tick();
    mem_valid = 1'b0;
    tick();
    tick();

    // Reset asserted while a write is visible
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h0BAD_F00D;
    tick();
    mem_valid = 1'b0;
    #1;
    chk("pre_reset_wen", {63'd0, RegW_EN_out}, 64'd1);
    reset = 1'b1;
    #1;
    chk("async_wen", {63'd0, RegW_EN_out}, 64'd0);
    chk("async_addr", {59'd0, addrD_out}, 64'd0);
    chk("async_data", {32'd0, WriteData}, 64'd0);
    q.delete();
    mWait    = 0;
    lastAddr = '0;
    lastData = '0;
    mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'h0000_AAAA;
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_mem", {63'd0, grantMem}, 64'd1);
    mem_valid = 1'b0;
    tick();
    tick();

    // Random stream; requesters hold until their transfer
    xfers  = 0;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!alu_valid || grantAlu) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_addr  = AW'($urandom);
        alu_data  = DW'($urandom);
      end
      if (!mem_valid || grantMem) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_addr  = AW'($urandom);
        mem_data  = DW'($urandom);
      end
      rf_stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    rf_stall  = 1'b0;
    tick();
    tick();
    chk("pulse_count", 64'(pulses), 64'(xfers));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
